data_mem_unit: RTL and testbench
================================

# data_mem_unit

Parametrised, byte-addressable data memory for the RISC-V datapath, replacing the fixed 32-byte, address-triggered store with a clocked, handshaked unit. It supports RV32I load/store sizes (LB/LH/LW/LBU/LHU, SB/SH/SW) with byte-lane steering and sign/zero extension. It also flags misaligned, out-of-range and illegal-size accesses. After reset, it fills its array with a known pattern using a word-per-cycle initialisation state machine. It sits between the execute stage and the write-back mux.

## Interface
- DEPTH_BYTES, 256: memory size in bytes; power of two, ≥ 8.
- ADDR_W, $clog2(DEPTH_BYTES): internal byte-address width.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  access request.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I size code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, LSB-aligned.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  32  load result, extended; 0 for stores and errors.
- rsp_err  out  1  access rejected.
- init_busy  out  1  initialisation in progress.

## Operation
- States: INIT, IDLE.
- reset sends the unit to INIT, clears the word counter, and clears rsp_valid, rsp_err and rsp_rdata to 0. After reset, init_busy = 1 and req_ready = 0.
- INIT writes word k = {8'(4k+3), 8'(4k+2), 8'(4k+1), 8'(4k)}, one word per cycle, k = 0 … DEPTH_BYTES/4−1. After the last word, the unit moves to IDLE.
- IDLE: req_ready = 1. A request is accepted on any edge where req_valid && req_ready.
- Error conditions (any one gives rsp_err = 1, no memory change, rsp_rdata = 0):
  - req_addr[31:ADDR_W] ≠ 0;
  - H/HU with addr[0] ≠ 0;
  - W with addr[1:0] ≠ 0;
  - funct3 ∈ {011, 110, 111};
  - store with funct3 = 100 or 101.
- Store: only the addressed lanes are written. SB writes wdata[7:0] to byte addr. SH writes wdata[15:0] to bytes addr and addr+1, little-endian. SW writes 4 bytes.
- Load: bytes are read little-endian. B and H results are sign-extended from bit 7 or bit 15. BU and HU results are zero-extended.
- No response backpressure: a response is always consumed.

## Timing
- Accepted request at edge N gives rsp_valid = 1 during cycle N+1 for exactly one cycle.
- A store commits at edge N.
- Full throughput: one access per cycle, back-to-back.
- A load in cycle N+1 to the address stored at edge N returns the new data; there is no bypass hazard.
- Init takes DEPTH_BYTES/4 cycles after reset deasserts. req_ready rises in the first IDLE cycle.
- Reset asserted mid-operation drops any pending response: rsp_valid = 0 on the next edge. An in-flight store accepted on that same edge is not committed. Init restarts from k = 0.
- Requests presented while req_ready = 0 are ignored and never buffered.

## Structure
- Package dmem_pkg contains:
  - funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - state enum {ST_INIT, ST_IDLE}.
- Sub-module dmem_lane_align (combinational) produces the 4-bit byte-enable, the shifted write data, and the extracted/extended load data from addr[1:0] and funct3.
- Top level holds the array, FSM, init counter, error check and response registers.

## Test plan
- Reset, wait for init_busy = 0, then LW 0x04 → rsp_rdata = 0x07060504, rsp_err = 0, exactly DEPTH_BYTES/4 init cycles.
- LB 0x83 → 0xFFFFFF83; LBU 0x83 → 0x00000083; LH 0x82 → 0xFFFF8382; LHU 0x82 → 0x00008382.
- SH 0xDEADBEEF to 0x06, next-cycle LW 0x04 → 0xBEEF0504. SB 0x5A to 0x05, then LW 0x04 → 0xBEEF5A04.
- LW 0x02, SH 0x01, LW 0x100 (DEPTH 256), funct3 = 011 → each returns rsp_err = 1 and rsp_rdata = 0; a subsequent LW of affected words shows no change.
- Back-to-back SW 0x11223344 to 0x10, then LW 0x10 on consecutive cycles → rsp_valid on both cycles, load returns 0x11223344.
- Assert reset on the same edge as SW 0xFFFFFFFF to 0x08 → no rsp_valid. After re-init, LW 0x08 → 0x0B0A0908.

Source files
------------

// File: rtl/data_mem_unit_pkg.sv
// Shared definitions for the byte-addressable data memory: RV32I size codes,
// controller state encoding and the power-up fill pattern.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_t;

  // Fill pattern for word k: every byte holds the low 8 bits of its own address.
  function automatic logic [31:0] f_init_word(input logic [7:0] k);
    logic [7:0] base;
    base = k << 2;
    return {base + 8'd3, base + 8'd2, base + 8'd1, base};
  endfunction

endpackage

// File: rtl/data_mem_unit_if.sv
// Request/response bundle between the execute stage and the data memory.
interface data_mem_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        init_busy;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_busy
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, init_busy
  );
endinterface

// File: rtl/data_mem_unit_lane_align.sv
// Byte-lane steering: byte enables and shifted store data for writes, and
// lane extraction with sign/zero extension for loads.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [31:0] w_rshift;

  function automatic logic signed [31:0] f_sext8(input logic [7:0] b);
    return {{24{b[7]}}, b};
  endfunction

  function automatic logic signed [31:0] f_sext16(input logic [15:0] h);
    return {{16{h[15]}}, h};
  endfunction

  assign w_rshift = i_rword >> {i_addr_lo, 3'b000};

  // Lane mask, write-data placement and load extension per size code.
  always_comb begin
    o_be    = 4'b0000;
    o_wdata = i_wdata << {i_addr_lo, 3'b000};
    o_rdata = '0;
    case (i_funct3)
      F3_B: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_rdata = f_sext8(w_rshift[7:0]);
      end
      F3_BU: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_rdata = {24'd0, w_rshift[7:0]};
      end
      F3_H: begin
        o_be    = 4'b0011 << i_addr_lo;
        o_rdata = f_sext16(w_rshift[15:0]);
      end
      F3_HU: begin
        o_be    = 4'b0011 << i_addr_lo;
        o_rdata = {16'd0, w_rshift[15:0]};
      end
      F3_W: begin
        o_be    = 4'b1111;
        o_rdata = i_rword;
      end
      default: begin
        o_be    = 4'b0000;
        o_rdata = '0;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_unit.sv
// Clocked, handshaked byte-addressable data memory. Fills itself with a known
// pattern after reset, then serves one load/store per cycle with a
// single-cycle registered response.
module data_mem_unit
  import dmem_pkg::*;
#(
  parameter int DEPTH_BYTES = 256,
  parameter int ADDR_W      = $clog2(DEPTH_BYTES)
) (
  input  logic           clk,
  input  logic           reset,
  data_mem_unit_if.slave bus
);

  localparam int WORDS = DEPTH_BYTES / 4;
  localparam int KW    = ADDR_W - 2;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [KW-1:0]     r_init_k;
  logic              w_init_we;
  logic              w_init_busy;
  logic              w_ready;

  logic [31:0]       r_mem [WORDS];

  logic              w_accept;
  logic              w_err;
  logic [KW-1:0]     w_word_idx;
  logic [31:0]       w_rword;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata_sh;
  logic [31:0]       w_rdata_ext;

  logic              r_rsp_vld_p1;
  logic              r_rsp_err_p1;
  logic [31:0]       r_rsp_rdata_p1;

  assign w_accept   = bus.req_valid && w_ready;
  assign w_word_idx = bus.req_addr[ADDR_W-1:2];
  assign w_rword    = r_mem[w_word_idx];

  dmem_lane_align u_align (
    .i_addr_lo (bus.req_addr[1:0]),
    .i_funct3  (bus.req_funct3),
    .i_wdata   (bus.req_wdata),
    .i_rword   (w_rword),
    .o_be      (w_be),
    .o_wdata   (w_wdata_sh),
    .o_rdata   (w_rdata_ext)
  );

  // Controller state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_INIT;
    else       r_state <= w_state_nxt;
  end

  // Init word counter; wraps to zero naturally after the last word.
  always_ff @(posedge clk) begin
    if (reset)          r_init_k <= '0;
    else if (w_init_we) r_init_k <= r_init_k + 1'b1;
  end

  // Next state and state-derived control.
  always_comb begin
    w_state_nxt = r_state;
    w_init_we   = 1'b0;
    w_init_busy = 1'b0;
    w_ready     = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_init_we   = 1'b1;
        w_init_busy = 1'b1;
        if (&r_init_k) w_state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        w_ready = 1'b1;
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  // Access legality: range, alignment, unknown size codes, unsigned stores.
  always_comb begin
    w_err = |bus.req_addr[31:ADDR_W];
    case (bus.req_funct3)
      F3_B:    w_err = w_err;
      F3_BU:   w_err = w_err | bus.req_we;
      F3_H:    w_err = w_err | bus.req_addr[0];
      F3_HU:   w_err = w_err | bus.req_addr[0] | bus.req_we;
      F3_W:    w_err = w_err | (|bus.req_addr[1:0]);
      default: w_err = 1'b1;
    endcase
  end

  // Array writes: init fill or lane-masked store; a reset edge blocks both.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_init_we) begin
        r_mem[r_init_k] <= f_init_word(8'(r_init_k));
      end else if (w_accept && bus.req_we && !w_err) begin
        for (int i = 0; i < 4; i++) begin
          if (w_be[i]) r_mem[w_word_idx][8*i +: 8] <= w_wdata_sh[8*i +: 8];
        end
      end
    end
  end

  // Response stage: one strobe per accepted request, data only for good loads.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp_vld_p1   <= 1'b0;
      r_rsp_err_p1   <= 1'b0;
      r_rsp_rdata_p1 <= '0;
    end else begin
      r_rsp_vld_p1   <= w_accept;
      r_rsp_err_p1   <= w_accept && w_err;
      r_rsp_rdata_p1 <= (w_accept && !w_err && !bus.req_we) ? w_rdata_ext : 32'd0;
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.init_busy = w_init_busy;
  assign bus.rsp_valid = r_rsp_vld_p1;
  assign bus.rsp_err   = r_rsp_err_p1;
  assign bus.rsp_rdata = r_rsp_rdata_p1;

endmodule

// File: tb/tb_data_mem_unit.sv
// Bench for data_mem_unit: directed vector table, reset/init sequences and a
// randomized run against a byte-array reference model.
module tb_data_mem_unit;
  import dmem_pkg::*;

  localparam int DEPTH = 256;

  logic clk;
  logic reset;
  data_mem_unit_if bus();

  data_mem_unit #(.DEPTH_BYTES(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  byte unsigned model_mem [DEPTH];

  typedef struct {
    string      name;
    bit         we;
    bit [2:0]   f3;
    bit [31:0]  addr;
    bit [31:0]  wdata;
    bit         exp_err;
    bit [31:0]  exp_rdata;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic void model_init();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'(i);
  endfunction

  function automatic void model_access(input bit we, input bit [2:0] f3, input bit [31:0] addr,
                                       input bit [31:0] wd, output bit err, output bit [31:0] rd);
    int size;
    longint val;
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    err = (addr >= DEPTH) || (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) ||
          (we && f3[2]) || ((addr % size) != 0);
    rd = 32'd0;
    if (err) return;
    if (we) begin
      for (int i = 0; i < size; i++) model_mem[addr + i] = wd[8*i +: 8];
    end else begin
      val = 0;
      for (int i = 0; i < size; i++) val = val + (longint'(model_mem[addr + i]) << (8 * i));
      if (!f3[2] && size < 4 && val >= (longint'(1) << (8 * size - 1)))
        val = val - (longint'(1) << (8 * size));
      rd = val[31:0];
    end
  endfunction

  // Present one request for one edge; outputs are sampled 1 time unit later.
  task automatic access(input bit we, input bit [2:0] f3, input bit [31:0] addr, input bit [31:0] wd);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    @(posedge clk);
    #1;
    bus.req_valid  = 1'b0;
  endtask

  task automatic idle_cycle();
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Count edges until init finishes, with a store held on the bus throughout.
  task automatic wait_init(input string tag);
    int cycles;
    bit vld_seen;
    cycles = 0;
    vld_seen = 0;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = F3_W;
    bus.req_addr   = 32'h30;
    bus.req_wdata  = 32'hFFFF_FFFF;
    while (bus.init_busy === 1'b1 && cycles < 1000) begin
      @(posedge clk);
      #1;
      cycles++;
      if (bus.rsp_valid !== 1'b0) vld_seen = 1;
      if (bus.init_busy !== 1'b1) bus.req_valid = 1'b0;
    end
    bus.req_valid = 1'b0;
    chk({tag, "_init_cycles"}, cycles, DEPTH / 4);
    chk({tag, "_no_rsp_in_init"}, {31'd0, vld_seen}, 32'd0);
    chk({tag, "_ready_after_init"}, {31'd0, bus.req_ready}, 32'd1);
  endtask

  vec_t vecs [$];

  initial begin
    bit e;
    bit [31:0] r;
    bit we;
    bit [2:0] f3;
    bit [31:0] addr, wd;

    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;

    vecs.push_back('{"lw04",      0, F3_W,   32'h04,  32'h0,         0, 32'h07060504});
    vecs.push_back('{"lb83",      0, F3_B,   32'h83,  32'h0,         0, 32'hFFFFFF83});
    vecs.push_back('{"lbu83",     0, F3_BU,  32'h83,  32'h0,         0, 32'h00000083});
    vecs.push_back('{"lh82",      0, F3_H,   32'h82,  32'h0,         0, 32'hFFFF8382});
    vecs.push_back('{"lhu82",     0, F3_HU,  32'h82,  32'h0,         0, 32'h00008382});
    vecs.push_back('{"sh06",      1, F3_H,   32'h06,  32'hDEADBEEF,  0, 32'h0});
    vecs.push_back('{"lw04_sh",   0, F3_W,   32'h04,  32'h0,         0, 32'hBEEF0504});
    vecs.push_back('{"sb05",      1, F3_B,   32'h05,  32'hAAAABB5A,  0, 32'h0});
    vecs.push_back('{"lw04_sb",   0, F3_W,   32'h04,  32'h0,         0, 32'hBEEF5A04});
    vecs.push_back('{"lw02_mis",  0, F3_W,   32'h02,  32'h0,         1, 32'h0});
    vecs.push_back('{"sh01_mis",  1, F3_H,   32'h01,  32'h12345678,  1, 32'h0});
    vecs.push_back('{"lw100_oob", 0, F3_W,   32'h100, 32'h0,         1, 32'h0});
    vecs.push_back('{"f3_011",    0, 3'b011, 32'h00,  32'h0,         1, 32'h0});
    vecs.push_back('{"sbu20_ill", 1, F3_BU,  32'h20,  32'h11111111,  1, 32'h0});
    vecs.push_back('{"lw00_keep", 0, F3_W,   32'h00,  32'h0,         0, 32'h03020100});
    vecs.push_back('{"lw20_keep", 0, F3_W,   32'h20,  32'h0,         0, 32'h23222120});
    vecs.push_back('{"sw10",      1, F3_W,   32'h10,  32'h11223344,  0, 32'h0});
    vecs.push_back('{"lw10_b2b",  0, F3_W,   32'h10,  32'h0,         0, 32'h11223344});
    vecs.push_back('{"lw30_ign",  0, F3_W,   32'h30,  32'h0,         0, 32'h33323130});

    // Reset state.
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_err",   {31'd0, bus.rsp_err},   32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata,          32'd0);
    chk("rst_init_busy", {31'd0, bus.init_busy}, 32'd1);
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
    reset = 1'b0;
    model_init();
    wait_init("first");

    // Directed table, applied back-to-back.
    foreach (vecs[i]) begin
      access(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata);
      model_access(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, e, r);
      chk({vecs[i].name, "_vld"},   {31'd0, bus.rsp_valid}, 32'd1);
      chk({vecs[i].name, "_err"},   {31'd0, bus.rsp_err},   {31'd0, vecs[i].exp_err});
      chk({vecs[i].name, "_rdata"}, bus.rsp_rdata,          vecs[i].exp_rdata);
    end
    idle_cycle();
    chk("idle_no_vld", {31'd0, bus.rsp_valid}, 32'd0);

    // Randomized accesses against the reference model.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        idle_cycle();
        chk("rand_idle_vld", {31'd0, bus.rsp_valid}, 32'd0);
      end else begin
        we = 1'($urandom_range(0, 1));
        f3 = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
        if ($urandom_range(0, 1) == 1) f3[2] = ~we & f3[2] | (f3 != 3'd2 && !we && $urandom_range(0, 1) == 1);
        addr = ($urandom_range(0, 19) == 0) ? 32'($urandom) : 32'($urandom_range(0, DEPTH - 1));
        if ($urandom_range(0, 3) != 0 && f3[1:0] != 2'd0) addr[0] = 1'b0;
        if ($urandom_range(0, 3) != 0 && f3[1:0] == 2'd2) addr[1] = 1'b0;
        wd = $urandom;
        access(we, f3, addr, wd);
        model_access(we, f3, addr, wd, e, r);
        chk("rand_vld",   {31'd0, bus.rsp_valid}, 32'd1);
        chk("rand_err",   {31'd0, bus.rsp_err},   {31'd0, e});
        chk("rand_rdata", bus.rsp_rdata,          r);
      end
    end

    // Reset on the same edge as an accepted store: no response, no commit.
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = F3_W;
    bus.req_addr   = 32'h08;
    bus.req_wdata  = 32'hFFFF_FFFF;
    reset = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    reset = 1'b0;
    chk("rstmid_no_vld",    {31'd0, bus.rsp_valid}, 32'd0);
    chk("rstmid_init_busy", {31'd0, bus.init_busy}, 32'd1);
    model_init();
    wait_init("second");
    access(1'b0, F3_W, 32'h08, 32'h0);
    chk("reinit_lw08_vld", {31'd0, bus.rsp_valid}, 32'd1);
    chk("reinit_lw08",     bus.rsp_rdata,          32'h0B0A0908);
    access(1'b0, F3_W, 32'h04, 32'h0);
    chk("reinit_lw04",     bus.rsp_rdata,          32'h07060504);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
